// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// ALU selector codes, controller FSM encoding and sizing helpers.
package alu_share_ctrl_pkg;

  localparam int DEFAULT_W = 8;

  // ALU selector codes. The controller forwards sel undecoded; these names
  // exist so callers and models agree on what each code means.
  localparam logic [3:0] SEL_ADD   = 4'h0;
  localparam logic [3:0] SEL_SUB   = 4'h1;
  localparam logic [3:0] SEL_AND   = 4'h2;
  localparam logic [3:0] SEL_OR    = 4'h3;
  localparam logic [3:0] SEL_XOR   = 4'h4;
  localparam logic [3:0] SEL_NOTA  = 4'h5;
  localparam logic [3:0] SEL_SHL   = 4'h6;
  localparam logic [3:0] SEL_SHR   = 4'h7;
  localparam logic [3:0] SEL_INC   = 4'h8;
  localparam logic [3:0] SEL_DEC   = 4'h9;
  localparam logic [3:0] SEL_PASSA = 4'hA;
  localparam logic [3:0] SEL_PASSB = 4'hB;
  localparam logic [3:0] SEL_NAND  = 4'hC;
  localparam logic [3:0] SEL_NOR   = 4'hD;
  localparam logic [3:0] SEL_XNOR  = 4'hE;
  localparam logic [3:0] SEL_ROL   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Width of the latency down-counter; a combinational ALU still needs one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector; the priority pointer moves to the other requester on each accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic fav1;

  // Lone requester always wins; a tie is broken by the pointer.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = fav1 ? 2'b10 : 2'b01;
  end

  // After serving requester 0 favour requester 1, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) fav1 <= 1'b0;
    else if (adv) fav1 <= gnt[0];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters. Operations are accepted
// one at a time in round-robin order, held on the ALU for its latency, and the
// result is presented to the owning requester until it takes it.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  output logic         busy
);

  localparam int            CW       = cnt_width(ALU_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT);

  state_t        state;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          accept;
  logic          owner_take;

  // Requests are only offered to the arbiter while idle, so no grant can
  // appear during EXEC or RESP.
  assign req        = (state == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign req0_ready = (state == ST_IDLE) & gnt[0];
  assign req1_ready = (state == ST_IDLE) & gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign owner_take = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == ST_RESP) & ~owner;
  assign rsp1_valid = (state == ST_RESP) &  owner;
  assign busy       = (state != ST_IDLE);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (accept),
    .gnt (gnt)
  );

  // Controller FSM: accept -> wait out ALU latency -> hold result for owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a   <= gnt[1] ? req1_a   : req0_a;
            alu_b   <= gnt[1] ? req1_b   : req0_b;
            alu_sel <= gnt[1] ? req1_sel : req0_sel;
            owner   <= gnt[1];
            cnt     <= CNT_INIT;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data <= alu_out;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_take) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
